// File: rtl/results_writeback.sv
// Result-stream writeback: tags each drained beat with its byte address in C
// and queues it through a small FIFO toward a valid/ready memory write port.
module results_writeback #(
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned ARRAY_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned BUS_WIDTH    = 256,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           m,
    input  logic [15:0]           p,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned EPB        = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned BPR        = ARRAY_WIDTH / EPB;
    localparam int unsigned BYTES      = DATA_WIDTH / 8;
    localparam int unsigned BEAT_BYTES = EPB * BYTES;
    localparam int unsigned K_W        = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int unsigned R_W        = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t state_q, state_d;
    logic   done_d;

    logic [15:0]           m_q, p_q, tc_q, tr_q;
    logic [K_W-1:0]        k_q;
    logic [R_W-1:0]        r_q;
    logic [ADDR_WIDTH-1:0] tile_row_addr, row_addr;

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;

    logic                  start_ok, zero_job, beat_in, last_beat;
    logic                  pop, head_free, fifo_full, push, drop, wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] p_bytes, tile_row_step, beat_addr;

    assign start_ok  = start && (state_q == IDLE);
    assign zero_job  = (m == 16'd0) || (p == 16'd0);
    assign beat_in   = in_valid && (state_q == RUN);
    assign last_beat = beat_in && (tr_q == m_q - 16'(ARRAY_HEIGHT)) && (tc_q == p_q - 16'(ARRAY_WIDTH))
                       && (r_q == R_W'(ARRAY_HEIGHT - 1)) && (k_q == K_W'(BPR - 1));

    assign p_bytes       = ADDR_WIDTH'(p_q) * ADDR_WIDTH'(BYTES);
    assign tile_row_step = p_bytes * ADDR_WIDTH'(ARRAY_HEIGHT);
    assign beat_addr     = row_addr + ADDR_WIDTH'(tc_q) * ADDR_WIDTH'(BYTES)
                           + ADDR_WIDTH'(k_q) * ADDR_WIDTH'(BEAT_BYTES);

    // The mem_* register is the FIFO head; the array holds the remaining FIFO_DEPTH-1 entries.
    assign pop       = mem_valid && mem_ready;
    assign head_free = !mem_valid || pop;
    assign fifo_full = mem_valid && (fifo_cnt == CNT_W'(FIFO_DEPTH - 1));
    assign push      = beat_in && (!fifo_full || pop);
    assign drop      = beat_in && !push;
    assign rd_en     = head_free && (fifo_cnt != '0);
    assign wr_en     = push && !(head_free && (fifo_cnt == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_job) done_d  = 1'b1;
                    else          state_d = RUN;
                end
            end
            RUN: begin
                if (last_beat) state_d = DRAIN;
            end
            DRAIN: begin
                if (!mem_valid || (pop && fifo_cnt == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address walk: k inner, tile row r, tile column tc, tile row block tr outer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q           <= '0;
            p_q           <= '0;
            tc_q          <= '0;
            tr_q          <= '0;
            k_q           <= '0;
            r_q           <= '0;
            tile_row_addr <= '0;
            row_addr      <= '0;
            overflow      <= 1'b0;
        end else if (start_ok) begin
            m_q           <= m;
            p_q           <= p;
            tc_q          <= '0;
            tr_q          <= '0;
            k_q           <= '0;
            r_q           <= '0;
            tile_row_addr <= base_addr;
            row_addr      <= base_addr;
            overflow      <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (beat_in) begin
                if (k_q != K_W'(BPR - 1)) begin
                    k_q <= k_q + K_W'(1);
                end else begin
                    k_q <= '0;
                    if (r_q != R_W'(ARRAY_HEIGHT - 1)) begin
                        r_q      <= r_q + R_W'(1);
                        row_addr <= row_addr + p_bytes;
                    end else begin
                        r_q <= '0;
                        if (tc_q != p_q - 16'(ARRAY_WIDTH)) begin
                            tc_q     <= tc_q + 16'(ARRAY_WIDTH);
                            row_addr <= tile_row_addr;
                        end else begin
                            tc_q          <= '0;
                            tr_q          <= tr_q + 16'(ARRAY_HEIGHT);
                            tile_row_addr <= tile_row_addr + tile_row_step;
                            row_addr      <= tile_row_addr + tile_row_step;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (head_free) begin
                if (fifo_cnt != '0) begin
                    mem_valid <= 1'b1;
                    mem_addr  <= fifo_addr[rd_ptr];
                    mem_data  <= fifo_data[rd_ptr];
                end else if (push) begin
                    mem_valid <= 1'b1;
                    mem_addr  <= beat_addr;
                    mem_data  <= in_data;
                end else begin
                    mem_valid <= 1'b0;
                end
            end
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            fifo_cnt <= fifo_cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_addr[wr_ptr] <= beat_addr;
            fifo_data[wr_ptr] <= in_data;
        end
    end

endmodule
